nco_wavegen: RTL and testbench

Numerically controlled waveform generator. It produces an NBITS-wide sample stream (saw, triangle, square or sine) at a programmable frequency and amplitude, one sample per clock. It sits directly upstream of the `pdm` stage and drives its `din`. It replaces the fixed-rate `saw` divider: the waveform is set at run time through the SPI register path instead of by synthesis-time parameters.

---
 rtl/wave_pkg.sv | 26 ++
 rtl/nco_wavegen_if.sv | 24 ++
 rtl/quarter_sine_rom.sv | 27 ++
 rtl/nco_wavegen.sv | 125 ++++++++++++
 tb/tb_nco_wavegen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
// Shared constants for the NCO waveform generator: the wave_sel encoding
// and the quarter-wave sine table generator used at elaboration.
package wave_pkg;

    localparam logic [1:0] WAVE_SAW = 2'd0;
    localparam logic [1:0] WAVE_TRI = 2'd1;
    localparam logic [1:0] WAVE_SQR = 2'd2;
    localparam logic [1:0] WAVE_SIN = 2'd3;

    // round((2^(nbits-1)-1) * sin(pi/2 * (k+0.5) / 2^abits)); Taylor series keeps
    // it free of math-library calls and is exact to well below 1 LSB on [0, pi/2].
    function automatic int rom_entry(input int nbits, input int abits, input int k);
        real x;
        real term;
        real s;
        x    = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(2 ** abits);
        term = x;
        s    = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return $rtoi(real'((2 ** (nbits - 1)) - 1) * s + 0.5);
    endfunction

endpackage

// File: rtl/nco_wavegen_if.sv
// Control and sample bus of the NCO waveform generator.
interface nco_wavegen_if #(
    parameter int NBITS      = 10,
    parameter int PHASE_BITS = 32
);
    logic                  en;
    logic [PHASE_BITS-1:0] freq_word;
    logic                  freq_load;
    logic [1:0]            wave_sel;
    logic [NBITS-1:0]      amp;
    logic [NBITS-1:0]      out;
    logic                  out_valid;
    logic                  wrap;

    modport master (
        output en, freq_word, freq_load, wave_sel, amp,
        input  out, out_valid, wrap
    );

    modport slave (
        input  en, freq_word, freq_load, wave_sel, amp,
        output out, out_valid, wrap
    );
endinterface

// File: rtl/quarter_sine_rom.sv
// Registered-output quarter-wave sine table, contents built at elaboration.
module quarter_sine_rom
    import wave_pkg::*;
#(
    parameter int NBITS     = 10,
    parameter int LUT_ABITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LUT_ABITS-1:0] addr,
    output logic [NBITS-2:0]     data
);
    localparam int DW    = NBITS - 1;
    localparam int DEPTH = 2 ** LUT_ABITS;

    logic [DW-1:0] tbl [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
        localparam logic [DW-1:0] VAL = DW'(rom_entry(NBITS, LUT_ABITS, k));
        assign tbl[k] = VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) data <= '0;
        else     data <= tbl[addr];
    end
endmodule

// File: rtl/nco_wavegen.sv
// Numerically controlled waveform generator: phase accumulator with
// wrap-synchronised frequency update, waveform stage and amplitude scaling.
module nco_wavegen
    import wave_pkg::*;
#(
    parameter int NBITS      = 10,
    parameter int PHASE_BITS = 32,
    parameter int LUT_ABITS  = 6
) (
    input logic          clk,
    input logic          rst,
    nco_wavegen_if.slave bus
);
    localparam int STAGES = 1;
    localparam int PW     = 2 * NBITS;
    localparam logic [NBITS-1:0] MAX    = '1;
    localparam logic [NBITS-1:0] MID    = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] MID_M1 = {1'b0, {(NBITS-1){1'b1}}};

    logic [PHASE_BITS-1:0] phase, inc_active, inc_shadow;
    logic                  pending, wrap_q;
    logic [PHASE_BITS:0]   sum;
    logic                  carry, xfer;

    assign sum   = {1'b0, phase} + {1'b0, inc_active};
    assign carry = bus.en & sum[PHASE_BITS];
    // Swap in the new increment only where it cannot cause a phase jump.
    assign xfer  = pending & (carry | ~bus.en | (inc_active == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= '0;
            inc_active <= '0;
            inc_shadow <= '0;
            pending    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            if (bus.en) phase <= sum[PHASE_BITS-1:0];
            wrap_q <= carry;
            if (bus.freq_load) begin
                inc_shadow <= bus.freq_word;
                if (xfer) begin
                    inc_active <= bus.freq_word;
                    pending    <= 1'b0;
                end else begin
                    pending    <= 1'b1;
                end
            end else if (xfer) begin
                inc_active <= inc_shadow;
                pending    <= 1'b0;
            end
        end
    end

    // Stage 1: waveform from the current phase.
    logic [NBITS:0]         p;
    logic [NBITS-1:0]       lin_nxt;
    logic [1:0]             quad;
    logic [LUT_ABITS-1:0]   idx, rom_addr;

    assign p        = phase[PHASE_BITS-1 -: NBITS+1];
    assign quad     = phase[PHASE_BITS-1 -: 2];
    assign idx      = phase[PHASE_BITS-3 -: LUT_ABITS];
    assign rom_addr = quad[0] ? ~idx : idx;

    always_comb begin
        lin_nxt = '0;
        case (bus.wave_sel)
            WAVE_SAW: lin_nxt = p[NBITS:1];
            WAVE_TRI: lin_nxt = p[NBITS] ? ~p[NBITS-1:0] : p[NBITS-1:0];
            WAVE_SQR: lin_nxt = phase[PHASE_BITS-1] ? '0 : MAX;
            default:  lin_nxt = '0;
        endcase
    end

    // Stage 2: the ROM register carries the sine path; the rest is registered alongside.
    logic [NBITS-2:0] rom_data;
    logic [NBITS-1:0] lin_q, sine_raw, raw;
    logic [1:0]       sel_q;
    logic             quad_hi_q;

    quarter_sine_rom #(.NBITS(NBITS), .LUT_ABITS(LUT_ABITS)) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lin_q     <= '0;
            sel_q     <= WAVE_SAW;
            quad_hi_q <= 1'b0;
        end else begin
            lin_q     <= lin_nxt;
            sel_q     <= bus.wave_sel;
            quad_hi_q <= quad[1];
        end
    end

    assign sine_raw = quad_hi_q ? (MID_M1 - {1'b0, rom_data}) : (MID + {1'b0, rom_data});
    assign raw      = (sel_q == WAVE_SIN) ? sine_raw : lin_q;

    // Stage 3: raw*(amp+1) never reaches 2^(2*NBITS), so the top product bit is dropped.
    logic [NBITS:0]   amp_p1;
    logic [NBITS-1:0] scaled, out_q;
    logic [STAGES:0]  vld_pipe;

    assign amp_p1 = {1'b0, bus.amp} + {{NBITS{1'b0}}, 1'b1};
    assign scaled = NBITS'((PW'(raw) * PW'(amp_p1)) >> NBITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            vld_pipe <= '0;
        end else begin
            out_q    <= scaled;
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
        end
    end

    assign bus.out       = out_q;
    assign bus.wrap      = wrap_q;
    assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_nco_wavegen.sv
// Self-checking bench for nco_wavegen: vector table, directed corner
// sequences and randomized traffic against a sample-level reference model.
module tb_nco_wavegen;
    import wave_pkg::*;

    localparam int NB = 10;
    localparam int PB = 32;
    localparam int LA = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nco_wavegen_if #(.NBITS(NB), .PHASE_BITS(PB)) bus ();

    nco_wavegen #(.NBITS(NB), .PHASE_BITS(PB), .LUT_ABITS(LA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    int rom_ref [64];

    longint m_phase, m_act, m_sh;
    bit     m_pend, m_wrap;
    int     m_raw, m_out, m_vcnt;

    typedef struct {
        bit          en;
        bit          ld;
        logic [31:0] fw;
        logic [1:0]  sel;
        logic [9:0]  amp;
        int          exp_out;
        bit          exp_wrap;
        bit          exp_valid;
    } vec_t;
    vec_t vecs [40];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got %0d expected %0d", name, step_no, act, exp);
        end
    endtask

    // Sample value for a given phase straight from the waveform definitions.
    function automatic int wave_ref(input longint ph, input logic [1:0] sel);
        longint pp, u;
        int q, i, r;
        case (sel)
            WAVE_SAW: return int'((ph >> 22) & 1023);
            WAVE_TRI: begin
                pp = ph >> 21;
                return int'((pp < 1024) ? pp : 2047 - pp);
            end
            WAVE_SQR: return (ph >= 64'h8000_0000) ? 0 : 1023;
            default: begin
                u = ph >> 24;
                q = int'(u >> 6);
                i = int'(u & 63);
                r = rom_ref[(q % 2 == 1) ? 63 - i : i];
                return (q < 2) ? 512 + r : 511 - r;
            end
        endcase
    endfunction

    task automatic step(input bit r, input bit e, input bit ld, input logic [31:0] fw,
                        input logic [1:0] sel, input logic [9:0] a);
        longint s;
        bit c, x;
        rst           = r;
        bus.en        = e;
        bus.freq_load = ld;
        bus.freq_word = fw;
        bus.wave_sel  = sel;
        bus.amp       = a;
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_act = 0; m_sh = 0; m_pend = 0; m_wrap = 0;
            m_raw = 0; m_out = 0; m_vcnt = 0; step_no = 0;
        end else begin
            s = m_phase + m_act;
            c = e && (s >= 64'h1_0000_0000);
            x = m_pend && (c || !e || m_act == 0);
            m_out = (m_raw * (int'(a) + 1)) >> 10;
            m_raw = wave_ref(m_phase, sel);
            if (e) m_phase = s & 64'hFFFF_FFFF;
            m_wrap = c;
            if (ld) begin
                m_sh = fw;
                if (x) begin m_act = fw; m_pend = 0; end
                else m_pend = 1;
            end else if (x) begin
                m_act = m_sh; m_pend = 0;
            end
            if (m_vcnt < 2) m_vcnt++;
            step_no++;
        end
        #1;
        check("out", bus.out, m_out);
        check("wrap", bus.wrap, m_wrap);
        check("out_valid", bus.out_valid, m_vcnt >= 2);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, WAVE_SAW, 0);
        step(1, 0, 0, 0, WAVE_SAW, 0);
    endtask

    initial begin
        int o [100];
        int s16 [16];
        int wr [4];
        int nw, n511, n0, mx, mn;
        logic [1:0] cs;
        logic [9:0] ca;
        logic [31:0] fw;

        for (int k = 0; k < 64; k++)
            rom_ref[k] = int'($floor(511.0 * $sin(3.14159265358979 / 2.0 * (k + 0.5) / 64.0) + 0.5));

        for (int r = 0; r < 40; r++) begin
            vecs[r].en        = 1'b1;
            vecs[r].ld        = (r == 0);
            vecs[r].fw        = 32'h1000_0000;
            vecs[r].sel       = WAVE_SAW;
            vecs[r].amp       = 10'd1023;
            vecs[r].exp_out   = (r < 4) ? 0 : 64 * ((r - 3) % 16);
            vecs[r].exp_wrap  = (r >= 17) && ((r - 17) % 16 == 0);
            vecs[r].exp_valid = (r >= 1);
        end

        // Reset state.
        do_reset();
        check("rst_out", bus.out, 0);
        check("rst_valid", bus.out_valid, 0);

        // Saw at full scale.
        for (int r = 0; r < 40; r++) begin
            step(0, vecs[r].en, vecs[r].ld, vecs[r].fw, vecs[r].sel, vecs[r].amp);
            check("tbl_out", bus.out, vecs[r].exp_out);
            check("tbl_wrap", bus.wrap, vecs[r].exp_wrap);
            check("tbl_valid", bus.out_valid, vecs[r].exp_valid);
        end

        // Square at half amplitude, continuing at the same frequency.
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, WAVE_SQR, 10'd511);
        n511 = 0; n0 = 0;
        for (int k = 0; k < 32; k++) begin
            step(0, 1, 0, 0, WAVE_SQR, 10'd511);
            if (bus.out == 511) n511++;
            if (bus.out == 0) n0++;
        end
        check("sqr_high_cnt", n511, 16);
        check("sqr_low_cnt", n0, 16);

        // Sine at full scale.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(0, 1, k == 0, 32'h1000_0000, WAVE_SIN, 10'd1023);
            if (k >= 3 && k < 19) s16[k-3] = int'(bus.out);
        end
        check("sin_first", s16[0], 518);
        mx = 0; mn = 1023;
        foreach (s16[j]) begin
            if (s16[j] > mx) mx = s16[j];
            if (s16[j] < mn) mn = s16[j];
        end
        check("sin_max", mx, 1023);
        check("sin_min", mn, 0);
        for (int j = 0; j < 8; j++) check("sin_sym", s16[j] + s16[j+8], 1023);

        // Deferred frequency change, loaded at phase 0x3000_0000.
        do_reset();
        nw = 0;
        for (int k = 0; k < 4; k++) wr[k] = -1;
        for (int k = 0; k < 40; k++) begin
            fw = (k == 0) ? 32'h1000_0000 : 32'h2000_0000;
            step(0, 1, (k == 0) || (k == 5), fw, WAVE_SAW, 10'd1023);
            if (bus.wrap && nw < 4) begin wr[nw] = k; nw++; end
        end
        check("defer_wrap0", wr[0], 17);
        check("defer_wrap1", wr[1], 25);
        check("defer_wrap2", wr[2], 33);

        // Triangle with a 5-cycle enable hold mid-ramp.
        do_reset();
        for (int k = 0; k < 80; k++) begin
            step(0, !(k >= 20 && k < 25), k == 0, 32'h0800_0000, WAVE_TRI, 10'd1023);
            o[k] = int'(bus.out);
        end
        for (int k = 22; k <= 26; k++) check("tri_hold", o[k], o[21]);
        mx = 0; mn = 1023;
        for (int k = 4; k < 80; k++) begin
            if (o[k] > mx) mx = o[k];
            if (o[k] < mn) mn = o[k];
        end
        check("tri_max", mx, 1023);
        check("tri_min", mn, 0);

        // Reset pulse at phase 0x8000_0000; nothing restarts without a reload.
        do_reset();
        for (int k = 0; k < 10; k++) step(0, 1, k == 0, 32'h1000_0000, WAVE_SAW, 10'd1023);
        step(1, 1, 0, 0, WAVE_SAW, 10'd1023);
        check("mid_rst_wrap", bus.wrap, 0);
        check("mid_rst_valid", bus.out_valid, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, WAVE_SAW, 10'd1023);
            check("mid_rst_out", bus.out, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        cs = WAVE_SAW; ca = 10'd1023;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) cs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) ca = 10'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0:       fw = 32'($urandom);
                1:       fw = 32'($urandom) >> 4;
                2:       fw = 32'h0;
                default: fw = 32'($urandom_range(1, 16)) << 26;
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 15) == 0, fw, cs, ca);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
